// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DM_ACC = 2'd1,
        IF_ACC = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// Counts access cycles without MemReady; flags when the wait limit is reached.
module mem_arbiter_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_c = (cnt_q == CNT_W'(TIMEOUT));

    // Clear while idle so every access starts from zero; saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !expired_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data accesses onto one single-port memory and stalls the pipeline.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IfReq,
    input  logic [ADDR_W-1:0] IfAddr,
    output logic [DATA_W-1:0] IfData,
    input  logic              DmRead,
    input  logic              DmWrite,
    input  logic [ADDR_W-1:0] DmAddr,
    input  logic [DATA_W-1:0] DmWData,
    output logic [DATA_W-1:0] DmRData,
    output logic              Stall,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemReady,
    output logic              BusErr
);

    arb_state_e        state_q, state_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              bus_err_q, bus_err_d;

    logic              dm_req_c;
    logic              in_acc_c;
    logic              stall_c;
    logic              expired_c;
    mem_cmd_t          cmd_c;

    assign dm_req_c = DmRead | DmWrite;
    assign in_acc_c = (state_q == DM_ACC) || (state_q == IF_ACC);
    assign stall_c  = (IfReq & ~if_done_q) | (dm_req_c & ~dm_done_q);

    mem_arbiter_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (Clk),
        .rst       (Reset),
        .clr       (state_q == IDLE),
        .inc       (in_acc_c & ~MemReady),
        .expired_c (expired_c)
    );

    // Next state, memory command mux, completion/abort handling and done flags.
    always_comb begin
        state_d    = state_q;
        if_done_d  = if_done_q;
        dm_done_d  = dm_done_q;
        if_data_d  = if_data_q;
        dm_rdata_d = dm_rdata_q;
        bus_err_d  = bus_err_q;
        cmd_c      = '0;

        case (state_q)
            IDLE: begin
                // Data access first: it belongs to the older instruction.
                if (dm_req_c && !dm_done_q) begin
                    state_d = DM_ACC;
                end else if (IfReq && !if_done_q) begin
                    state_d = IF_ACC;
                end
            end
            DM_ACC: begin
                cmd_c.we    = DmWrite;
                cmd_c.addr  = DmAddr;
                cmd_c.wdata = DmWData;
                // Stores never touch the load-data register, even on abort.
                if (MemReady) begin
                    if (!DmWrite) begin
                        dm_rdata_d = MemRData;
                    end
                    dm_done_d = 1'b1;
                    state_d   = IDLE;
                end else if (expired_c) begin
                    if (!DmWrite) begin
                        dm_rdata_d = '0;
                    end
                    bus_err_d = 1'b1;
                    dm_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            IF_ACC: begin
                cmd_c.addr = IfAddr;
                if (MemReady) begin
                    if_data_d = MemRData;
                    if_done_d = 1'b1;
                    state_d   = IDLE;
                end else if (expired_c) begin
                    if_data_d = '0;
                    bus_err_d = 1'b1;
                    if_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pipeline advances this cycle: next instruction starts with fresh flags.
        if (!stall_c) begin
            if_done_d = 1'b0;
            dm_done_d = 1'b0;
        end
    end

    // State and data registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            if_data_q  <= if_data_d;
            dm_rdata_q <= dm_rdata_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Request is dropped immediately while reset is held; the access is abandoned.
    assign MemReq   = in_acc_c & ~Reset;
    assign MemWe    = cmd_c.we & ~Reset;
    assign MemAddr  = cmd_c.addr;
    assign MemWData = cmd_c.wdata;
    assign Stall    = stall_c;
    assign IfData   = if_data_q;
    assign DmRData  = dm_rdata_q;
    assign BusErr   = bus_err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning max cycles waiting for MemReady before abort.
REQ-002 Clk  in  1  pipeline clock; all state changes on posedge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 IfReq  in  1  fetch stage requests instruction read.
REQ-005 IfAddr  in  32  fetch address (PC).
REQ-006 IfData  out  32  fetched instruction, valid when Stall=0 and IfReq=1.
REQ-007 DmRead  in  1  MEM-stage load (MemRead control line).
REQ-008 DmWrite  in  1  MEM-stage store (MemWrite control line).
REQ-009 DmAddr  in  32  data address (EX/MEM ALU result).
REQ-010 DmWData  in  32  store data (forwarded read data 2).
REQ-011 DmRData  out  32  load data, valid when Stall=0 and DmRead=1.
REQ-012 Stall  out  1  freeze whole pipeline (PC, all pipeline registers) while 1.
REQ-013 MemReq  out  1  unified single-port memory request.
REQ-014 MemWe  out  1  1 = write, 0 = read.
REQ-015 MemAddr  out  32  memory address.
REQ-016 MemWData  out  32  memory write data.
REQ-017 MemRData  in  32  memory read data, valid with MemReady.
REQ-018 MemReady  in  1  memory completes current access this cycle.
REQ-019 BusErr  out  1  sticky: an access timed out.

Function
REQ-020 DmReq = DmRead | DmWrite; DmRead and DmWrite both 1 SHALL be treated as write.
REQ-021 FSM states IDLE, DM_ACC, IF_ACC; Moore outputs MemReq=1 only in DM_ACC/IF_ACC.
REQ-022 Flags if_done, dm_done: set when the respective access completes; both cleared on any cycle with Stall=0.
REQ-023 Stall = (IfReq & ~if_done) | (DmReq & ~dm_done), combinational.
REQ-024 IDLE: DmReq & ~dm_done -> DM_ACC; else IfReq & ~if_done -> IF_ACC; else stay. Data access always wins (older instruction).
REQ-025 In DM_ACC: MemAddr=DmAddr, MemWe=DmWrite, MemWData=DmWData; in IF_ACC: MemAddr=IfAddr, MemWe=0, MemWData=0.
REQ-026 MemReady=1 in an access state: latch MemRData into DmRData (DM read) or IfData (IF), set done flag, -> IDLE.
REQ-027 Store completion SHALL leave DmRData unchanged.
REQ-028 Minimum latency: request seen in IDLE at cycle T, MemReady=1 at T+1 -> Stall=0 at T+2; both requests pending -> Stall=0 earliest at T+4.
REQ-029 Wait counter, width clog2(TIMEOUT+1), cleared on state entry, increments each access cycle with MemReady=0.
REQ-030 Counter reaching TIMEOUT: set BusErr, load 32'h0 into the data register, set done flag, -> IDLE (pipeline not deadlocked).
REQ-031 MemReady in IDLE SHALL be ignored.
REQ-032 Requests and addresses are stable while Stall=1; the block does not re-sample them mid-access.
REQ-033 No request pending: Stall=0, MemReq=0, one-cycle gap between consecutive accesses (via IDLE).

Reset
REQ-034 Reset=1 at any posedge, including mid-access: state IDLE, flags 0, counter 0, BusErr 0, IfData 0, DmRData 0.
REQ-035 During reset MemReq=0 and MemWe=0; an abandoned memory access is not retried or completed.

Structure
REQ-036 State encoding (2-bit IDLE=0, DM_ACC=1, IF_ACC=2) and TIMEOUT default SHALL live in the shared MIPS package.
REQ-037 Optional sub-module wait_timer (counter + expiry flag); everything else in mem_arbiter.
REQ-038 Top-level MIPS SHALL AND ~Stall into stallDetector and hold all pipeline registers when Stall=1.

Verification
REQ-039 IfReq=1, IfAddr=0x40, MemReady=1 first access cycle, MemRData=0x2002000A -> Stall high 2 cycles, IfData=0x2002000A, MemWe=0.
REQ-040 IfReq=1 and DmRead=1, DmAddr=0x100 -> DM_ACC (MemAddr=0x100) before IF_ACC (MemAddr=IfAddr); Stall=0 at T+4 with both data valid.
REQ-041 DmWrite=1, DmAddr=0x8, DmWData=0xDEADBEEF, MemReady after 3 cycles -> MemWe=1, MemWData=0xDEADBEEF throughout, DmRData unchanged.
REQ-042 MemReady held 0 with TIMEOUT=15 -> after 15 wait cycles BusErr=1, IfData=0, Stall drops, FSM IDLE.
REQ-043 Reset asserted in 2nd cycle of DM_ACC -> next cycle MemReq=0, Stall reflects only pending requests, BusErr=0, new access restarts from IDLE.
REQ-044 Spurious MemReady in IDLE with no requests -> no output, flag or state change.
